// File: rtl/sysarr_pkg.sv
// Shared constants, FSM encoding and lane helper for the systolic array feeder.
package sysarr_pkg;

  localparam int unsigned ARR_N  = 16;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Extract lane idx from a packed ARR_N-lane row vector.
  function automatic logic [DATA_W-1:0] lane_get(input logic [ARR_N*DATA_W-1:0] vec,
                                                 input int unsigned idx);
    return vec[idx*DATA_W +: DATA_W];
  endfunction

endpackage

// File: rtl/sysarr_skew_feeder_skew_line.sv
// DEPTH-stage enabled shift register of {valid, data}; DEPTH=0 is a plain wire.
module skew_line #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned DW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_ctl;
      assign unused_ctl = &{1'b0, clk, rst_n, en};
      assign out_valid  = in_valid;
      assign out_data   = in_data;
    end else begin : g_shift
      logic [DEPTH-1:0]         vld_q;
      logic [DEPTH-1:0][DW-1:0] dat_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          vld_q <= '0;
          dat_q <= '0;
        end else if (en) begin
          vld_q[0] <= in_valid;
          dat_q[0] <= in_data;
          for (int unsigned k = 1; k < DEPTH; k++) begin
            vld_q[k] <= vld_q[k-1];
            dat_q[k] <= dat_q[k-1];
          end
        end
      end

      assign out_valid = vld_q[DEPTH-1];
      assign out_data  = dat_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/sysarr_skew_feeder.sv
// Diagonal skew feeder: lane i of each accepted row reaches PE row i i cycles after lane 0,
// then the pipeline is flushed after the last row and done pulses.
module sysarr_skew_feeder
  import sysarr_pkg::*;
#(
  parameter int unsigned N  = ARR_N,
  parameter int unsigned DW = DATA_W,
  parameter int unsigned CW = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*DW-1:0] in_data,
  input  logic            in_last,
  input  logic            stall,
  output logic [N*DW-1:0] data_out,
  output logic [N-1:0]    lane_valid,
  output logic            active_out,
  output logic            busy,
  output logic            done
);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            done_d;
  logic            advance, ready_c, accept;
  logic [N-1:0]    skew_vld;
  logic [N*DW-1:0] skew_dat;

  assign advance = ~stall;
  assign ready_c = rst_n & advance & (state_q != DRAIN);
  assign accept  = in_valid & ready_c;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done    <= done_d;
    end
  end

  // Next-state logic; stall freezes everything because accept and drain both need advance
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE, FEED: begin
        if (accept) begin
          if (in_last) begin
            state_d = DRAIN;
            cnt_d   = CW'(N - 1);
          end else begin
            state_d = FEED;
          end
        end
      end
      DRAIN: begin
        if (advance) begin
          if (cnt_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake and array enable
  always_comb begin
    in_ready   = ready_c;
    busy       = (state_q != IDLE);
    active_out = rst_n & advance & ((state_q != IDLE) | accept);
  end

  // Per-lane skew; idle advancing cycles ingest zero bubbles
  for (genvar i = 0; i < N; i++) begin : g_lane
    skew_line #(
      .DEPTH(i),
      .DW   (DW)
    ) u_skew (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (advance),
      .in_valid (accept),
      .in_data  (accept ? in_data[i*DW +: DW] : DW'(0)),
      .out_valid(skew_vld[i]),
      .out_data (skew_dat[i*DW +: DW])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out   <= '0;
      lane_valid <= '0;
    end else if (advance) begin
      data_out   <= skew_dat;
      lane_valid <= skew_vld;
    end
  end

endmodule

// File: tb/tb_sysarr_skew_feeder.sv
// Scoreboard bench for sysarr_skew_feeder: per-lane expected queues plus flush/done tracking.
module tb_sysarr_skew_feeder;
  import sysarr_pkg::*;

  localparam int unsigned N  = ARR_N;
  localparam int unsigned DW = DATA_W;
  localparam int unsigned VW = N * DW;

  typedef struct packed {
    logic          v;
    logic [DW-1:0] d;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [VW-1:0] in_data;
  logic          in_last;
  logic          stall;
  logic [VW-1:0] data_out;
  logic [N-1:0]  lane_valid;
  logic          active_out;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  sysarr_skew_feeder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .stall     (stall),
    .data_out  (data_out),
    .lane_valid(lane_valid),
    .active_out(active_out),
    .busy      (busy),
    .done      (done)
  );

  ent_t lane_q [N][$];
  ent_t m_out  [N];
  logic m_busy, m_drain, m_done;
  int   m_left;
  int   cyc, first_cyc, exp_lat;
  int   checks = 0;
  int   errors = 0;

  task automatic check_val(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      lane_q[i].delete();
      m_out[i] = '0;
    end
    m_busy  = 1'b0;
    m_drain = 1'b0;
    m_done  = 1'b0;
    m_left  = 0;
  endtask

  // One clock: drive, compare mid-cycle, then advance the model at the edge
  task automatic tick(input logic v, input logic [VW-1:0] d, input logic l,
                      input logic s, input logic r);
    logic          exp_ready, acc, exp_act;
    logic [VW-1:0] exp_dat;
    logic [N-1:0]  exp_vld;
    in_valid = v;
    in_data  = d;
    in_last  = l;
    stall    = s;
    rst_n    = r;
    @(negedge clk);
    exp_ready = r & ~s & ~m_drain;
    acc       = v & exp_ready;
    exp_act   = r & ~s & (m_busy | acc);
    for (int i = 0; i < N; i++) begin
      exp_dat[i*DW +: DW] = m_out[i].d;
      exp_vld[i]          = m_out[i].v;
    end
    check_val("data_out", data_out, exp_dat);
    check_val("lane_valid", VW'(lane_valid), VW'(exp_vld));
    check_val("done", VW'(done), VW'(m_done));
    check_val("busy", VW'(busy), VW'(m_busy));
    check_val("in_ready", VW'(in_ready), VW'(exp_ready));
    check_val("active_out", VW'(active_out), VW'(exp_act));
    if (done === 1'b1 && exp_lat > 0)
      check_val("done_latency", VW'(cyc - first_cyc), VW'(exp_lat));
    @(posedge clk);
    if (!r) begin
      model_reset();
    end else begin
      m_done = 1'b0;
      if (!s) begin
        for (int i = 0; i < N; i++) begin
          lane_q[i].push_back(acc ? ent_t'({1'b1, lane_get(d, i)}) : ent_t'(0));
          if (lane_q[i].size() > i) m_out[i] = lane_q[i].pop_front();
        end
        if (m_drain) begin
          m_left--;
          if (m_left == 0) begin
            m_drain = 1'b0;
            m_busy  = 1'b0;
            m_done  = 1'b1;
          end
        end
      end
      if (acc) begin
        if (!m_busy) first_cyc = cyc;
        m_busy = 1'b1;
        if (l) begin
          m_drain = 1'b1;
          m_left  = N;
        end
      end
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(1'b0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  function automatic logic [VW-1:0] rand_vec();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [VW-1:0] ramp_vec(input int base);
    logic [VW-1:0] v;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'(base + i);
    return v;
  endfunction

  initial begin
    cyc       = 0;
    first_cyc = 0;
    exp_lat   = 0;
    model_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    stall    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tick(1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Single-vector batch straight into DRAIN
    exp_lat = 17;
    tick(1'b1, ramp_vec(1), 1'b1, 1'b0, 1'b1);
    idle(20);

    // Four back-to-back vectors
    exp_lat = 20;
    for (int k = 0; k < 4; k++) tick(1'b1, ramp_vec(16 * k), (k == 3), 1'b0, 1'b1);
    idle(20);

    // Gap of two cycles with a stray in_last that must be ignored
    exp_lat = 20;
    tick(1'b1, rand_vec(), 1'b0, 1'b0, 1'b1);
    tick(1'b0, rand_vec(), 1'b1, 1'b0, 1'b1);
    tick(1'b0, rand_vec(), 1'b1, 1'b0, 1'b1);
    tick(1'b1, rand_vec(), 1'b1, 1'b0, 1'b1);
    idle(20);

    // Three-cycle stall mid-FEED with in_valid held high
    exp_lat = 23;
    tick(1'b1, ramp_vec(0), 1'b0, 1'b0, 1'b1);
    tick(1'b1, ramp_vec(16), 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) tick(1'b1, ramp_vec(32), 1'b0, 1'b1, 1'b1);
    tick(1'b1, ramp_vec(32), 1'b0, 1'b0, 1'b1);
    tick(1'b1, ramp_vec(48), 1'b1, 1'b0, 1'b1);
    idle(22);

    // in_valid held through DRAIN; next vector taken only once back in IDLE
    exp_lat = 17;
    for (int k = 0; k < 20; k++) tick(1'b1, rand_vec(), 1'b1, 1'b0, 1'b1);
    idle(20);

    // Stall during DRAIN, then reset mid-DRAIN: no done may appear
    exp_lat = 0;
    tick(1'b1, rand_vec(), 1'b1, 1'b0, 1'b1);
    idle(3);
    tick(1'b0, '0, 1'b0, 1'b1, 1'b1);
    idle(2);
    tick(1'b1, rand_vec(), 1'b1, 1'b0, 1'b0);
    idle(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
